// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between an instruction-fetch requester (IF)
// and a load/store requester (LS). LS normally wins; IF is forced through
// after STARVE_LIMIT consecutive LS grants taken while IF was waiting.
// A branch/jump flush during an in-flight fetch lets the memory access finish
// but suppresses its ack and result.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   if_req/if_addr/if_flush         fetch request, address, flush
//   if_ack/if_rdata                 fetch done pulse, fetched word
//   ls_req/ls_we/ls_addr/ls_wdata/  load/store request and fields
//   ls_wstrb
//   ls_ack/ls_rdata                 access done pulse, load data
//   mem_req/mem_we/mem_addr/        memory request side (held until mem_ready)
//   mem_wdata/mem_wstrb
//   mem_ready/mem_rdata             memory completion and read data
//
// State table
//   state    | meaning
//   IDLE     | no transaction; arbitrate on this edge
//   SERVE_IF | fetch in flight, waiting for mem_ready
//   SERVE_LS | load/store in flight, waiting for mem_ready
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [3:0]        ls_wstrb,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SERVE_IF = 2'd1;
  localparam logic [1:0] SERVE_LS = 2'd2;

  localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

  logic [1:0]        state_q,      state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              drop_q,       drop_d;
  logic              mem_req_q,    mem_req_d;
  logic              mem_we_q,     mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
  logic [3:0]        mem_wstrb_q,  mem_wstrb_d;
  logic              if_ack_q,     if_ack_d;
  logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;
  logic              ls_ack_q,     ls_ack_d;
  logic [DATA_W-1:0] ls_rdata_q,   ls_rdata_d;

  logic if_waiting;
  logic if_elig;
  logic ls_elig;
  logic grant_ls;
  logic grant_if;

  // A requester still seeing its ack is finishing the previous access, so it
  // is not re-granted in the bubble cycle.
  assign if_waiting = if_req & ~if_flush;
  assign if_elig    = if_waiting & ~if_ack_q;
  assign ls_elig    = ls_req & ~ls_ack_q;
  assign grant_ls   = ls_elig & (~if_elig | (starve_cnt_q != LIMIT));
  assign grant_if   = if_elig & ~grant_ls;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    drop_d       = drop_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    if_ack_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    ls_ack_d     = 1'b0;
    ls_rdata_d   = ls_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_ls) begin
          state_d     = SERVE_LS;
          mem_req_d   = 1'b1;
          mem_we_d    = ls_we;
          mem_addr_d  = ls_addr;
          mem_wdata_d = ls_wdata;
          mem_wstrb_d = ls_we ? ls_wstrb : 4'd0;
          // Saturate at the limit so a grant taken while IF sits in its ack
          // cycle cannot push the count past the forcing point.
          if (!if_waiting)
            starve_cnt_d = 4'd0;
          else if (starve_cnt_q != LIMIT)
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else if (grant_if) begin
          state_d      = SERVE_IF;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wstrb_d  = 4'd0;
          starve_cnt_d = 4'd0;
        end else if (!if_req) begin
          starve_cnt_d = 4'd0;
        end
      end

      SERVE_IF: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          // A flush arriving in the completion cycle still kills the result.
          if (!(drop_q | if_flush)) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (if_flush) begin
          drop_d = 1'b1;
        end
      end

      SERVE_LS: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          ls_ack_d  = 1'b1;
          if (!mem_we_q)
            ls_rdata_d = mem_rdata;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      drop_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= 4'd0;
      if_ack_q     <= 1'b0;
      if_rdata_q   <= '0;
      ls_ack_q     <= 1'b0;
      ls_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      drop_q       <= drop_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      if_ack_q     <= if_ack_d;
      if_rdata_q   <= if_rdata_d;
      ls_ack_q     <= ls_ack_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign ls_ack    = ls_ack_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int SL = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, if_ack;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_ack;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_wstrb;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the memory (0 none, 1 fetch, 2 load/store),
  // how many LS grants IF has waited through, and whether the fetch is dead.
  int          owner;
  int          waited;
  bit          dead;
  logic        e_mem_req, e_mem_we, e_if_ack, e_ls_ack;
  logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_ls_rdata;
  logic [3:0]  e_mem_wstrb;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit if_ok, ls_ok, ls_win;
    if (reset) begin
      owner = 0; waited = 0; dead = 0;
      e_mem_req = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0; e_mem_wstrb = 0;
      e_if_ack = 0; e_if_rdata = 0; e_ls_ack = 0; e_ls_rdata = 0;
      return;
    end
    if (owner == 0) begin
      if_ok  = if_req && !if_flush && !e_if_ack;
      ls_ok  = ls_req && !e_ls_ack;
      ls_win = ls_ok && !(if_ok && waited == SL);
      e_if_ack = 0; e_ls_ack = 0;
      if (ls_win) begin
        owner = 2; e_mem_req = 1; e_mem_we = ls_we; e_mem_addr = ls_addr;
        e_mem_wdata = ls_wdata; e_mem_wstrb = ls_we ? ls_wstrb : 4'd0;
        if (if_req && !if_flush) waited = (waited < SL) ? waited + 1 : SL;
        else waited = 0;
      end else if (if_ok) begin
        owner = 1; e_mem_req = 1; e_mem_we = 0; e_mem_addr = if_addr;
        e_mem_wstrb = 0; waited = 0;
      end else if (!if_req) begin
        waited = 0;
      end
    end else begin
      e_if_ack = 0; e_ls_ack = 0;
      if (mem_ready) begin
        if (owner == 1) begin
          if (!dead && !if_flush) begin e_if_ack = 1; e_if_rdata = mem_rdata; end
          dead = 0;
        end else begin
          e_ls_ack = 1;
          if (!e_mem_we) e_ls_rdata = mem_rdata;
        end
        owner = 0; e_mem_req = 0;
      end else if (owner == 1 && if_flush) begin
        dead = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    chk_val("mem_req",   {31'd0, mem_req},   {31'd0, e_mem_req});
    chk_val("mem_we",    {31'd0, mem_we},    {31'd0, e_mem_we});
    chk_val("mem_addr",  mem_addr,           e_mem_addr);
    chk_val("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e_mem_wstrb});
    if (e_mem_req && e_mem_we) chk_val("mem_wdata", mem_wdata, e_mem_wdata);
    chk_val("if_ack",    {31'd0, if_ack},    {31'd0, e_if_ack});
    chk_val("if_rdata",  if_rdata,           e_if_rdata);
    chk_val("ls_ack",    {31'd0, ls_ack},    {31'd0, e_ls_ack});
    chk_val("ls_rdata",  ls_rdata,           e_ls_rdata);
  endtask

  function automatic bit roll(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  // Requesters hold their fields until acked (or flushed), then pick anew.
  task automatic drive(input int p_if, input int p_ls, input int p_fl,
                       input int p_rdy, input int p_rst);
    if (!if_req || e_if_ack || if_flush) begin
      if_req  = roll(p_if);
      if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!ls_req || e_ls_ack) begin
      ls_req   = roll(p_ls);
      ls_we    = roll(50);
      ls_addr  = $urandom & 32'hFFFF_FFFC;
      ls_wdata = $urandom;
      ls_wstrb = 4'($urandom);
    end
    if_flush  = roll(p_fl);
    mem_ready = roll(p_rdy);
    mem_rdata = $urandom;
    reset     = roll(p_rst);
  endtask

  initial begin
    reset = 1; if_req = 0; if_addr = 0; if_flush = 0;
    ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0; ls_wstrb = 0;
    mem_ready = 0; mem_rdata = 0;
    step();
    chk_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk_val("rst_mem_addr", mem_addr, 32'd0);
    reset = 0;

    // Single fetch with an immediately ready memory.
    if_req = 1; if_addr = 32'h10; mem_ready = 1; mem_rdata = 32'h0050_0093;
    step();
    chk_val("fetch_addr", mem_addr, 32'h10);
    step();
    chk_val("fetch_ack", {31'd0, if_ack}, 32'd1);
    chk_val("fetch_data", if_rdata, 32'h0050_0093);
    if_req = 0; mem_ready = 0;
    step();

    // Phases: balanced, LS-heavy (starvation), flush-heavy, slow memory with resets.
    for (int i = 0; i < 1000; i++) begin drive(50, 50, 5, 50, 0);  step(); end
    for (int i = 0; i < 1000; i++) begin drive(95, 95, 2, 70, 0);  step(); end
    for (int i = 0; i < 800;  i++) begin drive(80, 40, 30, 30, 0); step(); end
    for (int i = 0; i < 800;  i++) begin drive(60, 60, 10, 5, 2);  step(); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
